midi_note_decoder: RTL and testbench
====================================

Name: midi_note_decoder

Overview:
- Parses a serial MIDI byte stream (from the UART receiver) into single-cycle note_on / note_off strobes with a note number and velocity.
- Sits directly upstream of the monophonic note-priority stage, which samples note on a strobe and then stays busy for several cycles.
- Handles running status, channel filtering, "Note On with velocity 0 = Note Off", and interleaved real-time bytes.
- Spaces strobes by a guaranteed minimum gap so the downstream stage is always back in READY.

Parameters:
- GAP_CYCLES, 80, minimum clk cycles from one strobe to the next (must cover downstream worst case: 2*MAX_NOTES+8).
- GAP_W, 8, width of the gap counter; must hold GAP_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- byte_valid  in  1  one-cycle strobe, byte_data valid
- byte_data  in  8  received MIDI byte
- channel  in  4  MIDI channel to accept (0 = ch1)
- note_on  out  1  one-cycle strobe, key pressed
- note_off  out  1  one-cycle strobe, key released
- note  out  7  note number, held until next strobe
- velocity  out  7  velocity, held until next strobe (0 for note_off)
- overrun  out  1  one-cycle strobe, pending event overwritten

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset clears all outputs to 0. It also clears running status to none, the parser state to IDLE, the pending flag, and the gap counter. Reset mid-message discards the partial message.
- Byte classification, on byte_valid only:
  - 0xF8-0xFF (real-time): ignored entirely; parser state, running status and stored data untouched.
  - 0xF0-0xF7 (system common/SysEx): running status cleared, state -> IDLE; subsequent data bytes discarded.
  - 0x80-0xEF (channel status): latch as running status, state -> WAIT_D1; any partial message is aborted.
  - 0x00-0x7F (data): handled by the parser state below.
- Parser states:
  - IDLE: data bytes discarded.
  - WAIT_D1: store data byte as d1. If the status type is 0xC or 0xD (one-byte message), complete with d1 and stay in WAIT_D1. Otherwise go to WAIT_D2.
  - WAIT_D2: store d2, complete the message, return to WAIT_D1 (running status kept).
- On completion:
  - Discard unless status[3:0] == channel.
  - Type 0x9 with d2 != 0 -> note_on event (note=d1, velocity=d2).
  - Type 0x9 with d2 == 0, or type 0x8 -> note_off event (note=d1, velocity=0).
  - All other types produce no event.
- Event issue:
  - Each event is written to a 1-deep pending register.
  - When pending is set and the gap counter is 0: on the next clk edge, pulse note_on or note_off for one cycle, update note and velocity in that same cycle, clear pending, and load the gap counter with GAP_CYCLES-1. The counter then decrements to 0.
  - Latency: the strobe rises 1 cycle after the completing byte_valid when the gap counter is idle.
  - If a new event arrives while pending is still set, it overwrites pending and overrun pulses in that cycle.
  - If an event completes in the same cycle that the pending event is emitted, the new event becomes pending and no overrun is raised.
- note_on and note_off are never high in the same cycle. note and velocity never change except on a strobe.

Optional Feature:
- Macro: MIDI_NOTE_DECODER_OMNI_EN.
- Defined: the channel port is ignored and note events on all 16 channels are accepted.
- Undefined: only status[3:0] == channel is accepted.

Test Plan:
- channel=0; bytes 0x90,0x3C,0x64 -> one note_on, note=0x3C, velocity=0x64, 1 cycle after the third byte.
- After that: bytes 0x40,0x00 (running status) -> one note_off with note=0x40, no status byte needed. Then 0x80,0x3C,0x10 -> note_off, note=0x3C, velocity=0.
- Bytes 0x91,0x3C,0x64 with channel=0 -> no strobe. With the OMNI macro defined -> note_on, note=0x3C.
- Bytes 0x90,0x3C,0xF8,0x64 (clock byte inside message) -> note_on, note=0x3C, velocity=0x64. Bytes 0xF0,0x3C,0x64 -> no strobe, running status lost.
- Two complete note_on messages 3 cycles apart (GAP_CYCLES=80) -> second strobe exactly 80 cycles after the first. A third message inside the gap -> overrun pulse; only the latest of the pending events is emitted.
- Bytes 0x90,0x3C then rst for 1 cycle, then 0x64 -> no strobe; all outputs 0 after reset.

Source files
------------

// File: rtl/midi_note_decoder.sv
// MIDI byte-stream parser emitting spaced note_on/note_off strobes with note and velocity.
// Define MIDI_NOTE_DECODER_OMNI_EN to accept note events on all 16 channels.
module midi_note_decoder #(
   parameter int GAP_CYCLES = 80,
   parameter int GAP_W      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   input  logic [3:0] channel,
   output logic       note_on,
   output logic       note_off,
   output logic [6:0] note,
   output logic [6:0] velocity,
   output logic       overrun
);

   typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;

   state_t           state, state_nxt;
   logic [7:0]       status, status_nxt;
   logic [6:0]       d1, d1_nxt;
   logic             complete;
   logic [6:0]       msg_d1, msg_d2;
   logic             chan_ok, is_on, is_off, event_vld, fire;
   logic             pending, pend_on;
   logic [6:0]       pend_note, pend_vel;
   logic [GAP_W-1:0] gap;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         status <= '0;
         d1     <= '0;
      end else begin
         state  <= state_nxt;
         status <= status_nxt;
         d1     <= d1_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      status_nxt = status;
      d1_nxt     = d1;
      complete   = 1'b0;
      msg_d1     = d1;
      msg_d2     = '0;
      if (byte_valid) begin
         if (byte_data[7:3] == 5'b11111) begin
            // real-time bytes may interleave anywhere; leave parser untouched
         end else if (byte_data[7:4] == 4'hF) begin
            status_nxt = '0;
            state_nxt  = IDLE;
         end else if (byte_data[7]) begin
            status_nxt = byte_data;
            state_nxt  = WAIT_D1;
         end else begin
            case (state)
               WAIT_D1: begin
                  d1_nxt = byte_data[6:0];
                  if (status[7:4] == 4'hC || status[7:4] == 4'hD) begin
                     complete = 1'b1;
                     msg_d1   = byte_data[6:0];
                  end else begin
                     state_nxt = WAIT_D2;
                  end
               end
               WAIT_D2: begin
                  complete  = 1'b1;
                  msg_d2    = byte_data[6:0];
                  state_nxt = WAIT_D1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef MIDI_NOTE_DECODER_OMNI_EN
   logic unused_channel;
   assign unused_channel = ^channel;
   assign chan_ok = 1'b1;
`else
   assign chan_ok = (status[3:0] == channel);
`endif

   assign is_on     = (status[7:4] == 4'h9) && (msg_d2 != 7'd0);
   assign is_off    = ((status[7:4] == 4'h9) && (msg_d2 == 7'd0)) || (status[7:4] == 4'h8);
   assign event_vld = complete && chan_ok && (is_on || is_off);
   assign fire      = pending && (gap == '0);

   // Emission and capture share one block so a same-cycle arrival refills
   // pending after it drains, without flagging overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         note_on   <= 1'b0;
         note_off  <= 1'b0;
         note      <= '0;
         velocity  <= '0;
         overrun   <= 1'b0;
         pending   <= 1'b0;
         pend_on   <= 1'b0;
         pend_note <= '0;
         pend_vel  <= '0;
         gap       <= '0;
      end else begin
         note_on  <= 1'b0;
         note_off <= 1'b0;
         overrun  <= 1'b0;
         if (fire) begin
            note_on  <= pend_on;
            note_off <= !pend_on;
            note     <= pend_note;
            velocity <= pend_vel;
            pending  <= 1'b0;
            gap      <= GAP_W'(GAP_CYCLES - 1);
         end else if (gap != '0) begin
            gap <= gap - GAP_W'(1);
         end
         if (event_vld) begin
            pending   <= 1'b1;
            pend_on   <= is_on;
            pend_note <= msg_d1;
            pend_vel  <= is_on ? msg_d2 : 7'd0;
            overrun   <= pending && !fire;
         end
      end
   end

endmodule

// File: tb/tb_midi_note_decoder.sv
// Directed bench for midi_note_decoder: parsing, filtering, gap spacing, overrun, reset.
module tb_midi_note_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = '0;
   logic [3:0] channel = 4'd0;
   logic       note_on, note_off, overrun;
   logic [6:0] note, velocity;

   int passed = 0;
   int total  = 0;
   int cyc = 0;
   int on_cnt = 0, off_cnt = 0, ovr_cnt = 0, both_cnt = 0;
   int last_on_cyc = 0, prev_on_cyc = 0;
   int exp_on = 0;

   midi_note_decoder #(.GAP_CYCLES(80), .GAP_W(8)) dut (
      .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
      .channel(channel), .note_on(note_on), .note_off(note_off), .note(note),
      .velocity(velocity), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (note_on) begin
         on_cnt      <= on_cnt + 1;
         prev_on_cyc <= last_on_cyc;
         last_on_cyc <= cyc;
      end
      if (note_off) off_cnt <= off_cnt + 1;
      if (overrun) ovr_cnt <= ovr_cnt + 1;
      if (note_on && note_off) both_cnt <= both_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // called at a negedge; byte is sampled on the following posedge
   task automatic send(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      idle(3);
      rst = 1'b0;
      chk("rst_note_on", note_on, 0);
      chk("rst_note_off", note_off, 0);
      chk("rst_note", note, 0);
      chk("rst_velocity", velocity, 0);
      chk("rst_overrun", overrun, 0);

      // basic note_on with exact one-cycle latency
      send(8'h90); send(8'h3C); send(8'h64);
      chk("lat_before", note_on, 0);
      idle(1);
      chk("lat_on", note_on, 1);
      chk("lat_off", note_off, 0);
      chk("on1_note", note, 7'h3C);
      chk("on1_vel", velocity, 7'h64);
      exp_on++;
      idle(100);

      // running status, velocity 0 -> note_off
      send(8'h40); send(8'h00);
      idle(5);
      chk("rs_off_cnt", off_cnt, 1);
      chk("rs_note", note, 7'h40);
      chk("rs_vel", velocity, 0);
      idle(100);

      // explicit note_off, velocity forced to 0
      send(8'h80); send(8'h3C); send(8'h10);
      idle(5);
      chk("off_cnt", off_cnt, 2);
      chk("off_note", note, 7'h3C);
      chk("off_vel", velocity, 0);
      idle(100);

      // other channel
      send(8'h91); send(8'h3C); send(8'h64);
      idle(5);
`ifdef MIDI_NOTE_DECODER_OMNI_EN
      exp_on++;
      chk("ch1_note", note, 7'h3C);
`endif
      chk("ch1_on_cnt", on_cnt, exp_on);
      idle(100);

      // real-time byte inside a message
      send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
      exp_on++;
      idle(5);
      chk("rt_on_cnt", on_cnt, exp_on);
      chk("rt_note", note, 7'h3C);
      chk("rt_vel", velocity, 7'h64);
      idle(100);

      // system common clears running status
      send(8'hF0); send(8'h3C); send(8'h64);
      send(8'h3C); send(8'h64);
      idle(5);
      chk("sys_on_cnt", on_cnt, exp_on);
      chk("sys_off_cnt", off_cnt, 2);
      idle(100);

      // two messages three cycles apart: second strobe 80 cycles after first
      send(8'h90); send(8'h30); send(8'h50);
      send(8'h90); send(8'h31); send(8'h51);
      exp_on += 2;
      idle(95);
      chk("gap_on_cnt", on_cnt, exp_on);
      chk("gap_delta", last_on_cyc - prev_on_cyc, 80);
      chk("gap_note", note, 7'h31);
      chk("gap_vel", velocity, 7'h51);
      chk("gap_no_ovr", ovr_cnt, 0);
      idle(100);

      // third message inside the gap overwrites the pending one
      send(8'h90); send(8'h32); send(8'h52);
      send(8'h90); send(8'h33); send(8'h53);
      send(8'h90); send(8'h34); send(8'h54);
      exp_on += 2;
      idle(95);
      chk("ovr_cnt", ovr_cnt, 1);
      chk("ovr_on_cnt", on_cnt, exp_on);
      chk("ovr_delta", last_on_cyc - prev_on_cyc, 80);
      chk("ovr_note", note, 7'h34);
      chk("ovr_vel", velocity, 7'h54);
      idle(20);

      // reset mid-message discards the partial message
      send(8'h90); send(8'h3C);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      send(8'h64);
      idle(5);
      chk("mrst_on_cnt", on_cnt, exp_on);
      chk("mrst_note", note, 0);
      chk("mrst_vel", velocity, 0);
      chk("mrst_on", note_on, 0);
      chk("mrst_off", note_off, 0);
      chk("both_high", both_cnt, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
